// File: rtl/gf180mcu_dlyc_tap_calibrator.sv
// Purpose: launches an edge into a dlyc delay chain, captures the taps one CLK later and averages the crossed-tap count.
// Latency: START-accept edge to DONE cycle is 2^LOG_AVG*(4+SETTLE_CYC)+1 cycles (33 with defaults).
// Backpressure: none; START is only accepted in IDLE and is dropped (not queued) while a run is in progress.
module gf180mcu_dlyc_tap_calibrator #(
  parameter int N_TAPS     = 32,
  parameter int LOG_AVG    = 2,
  parameter int SETTLE_CYC = 4,
  localparam int CW        = $clog2(N_TAPS + 1)
) (
  input  logic              CLK,
  input  logic              RN,
  input  logic              START,
  output logic              LAUNCH,
  input  logic [N_TAPS-1:0] TAP,
  output logic              BUSY,
  output logic              DONE,
  output logic [CW-1:0]     CODE,
  output logic              SAT
);

  localparam int AW = CW + LOG_AVG;                 // accumulator width, sized so 2^LOG_AVG full counts fit
  localparam int MW = LOG_AVG + 1;                  // measurement counter must reach 2^LOG_AVG
  localparam int SW = $clog2(SETTLE_CYC + 1);
  localparam logic [MW-1:0] N_MEAS      = MW'(1 << LOG_AVG);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FIRE, S_CAP, S_SYNC, S_EVAL, S_SETTLE, S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic                launch_q, launch_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [CW-1:0]       code_q, code_d;
  logic                sat_q, sat_d;
  logic                run_sat_q, run_sat_d;
  logic [AW-1:0]       acc_q, acc_d;
  logic [MW-1:0]       meas_q, meas_d;
  logic [SW-1:0]       settle_q, settle_d;
  logic [N_TAPS-1:0]   cap1_q, cap1_d;
  logic [N_TAPS-1:0]   cap2_q, cap2_d;
  logic [CW-1:0]       cnt;
  logic                run_on;

  // Leading-match count: taps agreeing with LAUNCH from tap 0 up to the first disagreement; later bubbles ignored.
  always_comb begin
    cnt    = '0;
    run_on = 1'b1;
    for (int k = 0; k < N_TAPS; k++) begin
      if (run_on && (cap2_q[k] == launch_q)) cnt = CW'(k + 1);
      else                                   run_on = 1'b0;
    end
  end

  // Next-state and datapath for the launch/capture/average sequence.
  always_comb begin
    state_d   = state_q;
    launch_d  = launch_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    code_d    = code_q;
    sat_d     = sat_q;
    run_sat_d = run_sat_q;
    acc_d     = acc_q;
    meas_d    = meas_q;
    settle_d  = settle_q;
    cap1_d    = cap1_q;
    cap2_d    = cap2_q;
    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d   = S_FIRE;
          acc_d     = '0;
          meas_d    = '0;
          run_sat_d = 1'b0;
          busy_d    = 1'b1;
        end
      end
      S_FIRE: begin
        // Polarity alternates per measurement, so rising and falling edges are averaged together.
        launch_d = ~launch_q;
        state_d  = S_CAP;
      end
      S_CAP: begin
        // Exactly one CLK period after the launch edge.
        cap1_d  = TAP;
        state_d = S_SYNC;
      end
      S_SYNC: begin
        cap2_d  = cap1_q;
        state_d = S_EVAL;
      end
      S_EVAL: begin
        acc_d    = acc_q + AW'(cnt);
        meas_d   = meas_q + 1'b1;
        if (cnt == CW'(N_TAPS)) run_sat_d = 1'b1;
        settle_d = SETTLE_LAST;
        state_d  = S_SETTLE;
      end
      S_SETTLE: begin
        if (settle_q == '0) begin
          if (meas_q < N_MEAS) begin
            state_d = S_FIRE;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            code_d  = acc_q[AW-1:LOG_AVG];
            sat_d   = run_sat_q;
          end
        end else begin
          settle_d = settle_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset drops LAUNCH so the chain returns to 0 and discards any partial result.
  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      state_q   <= S_IDLE;
      launch_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      code_q    <= '0;
      sat_q     <= 1'b0;
      run_sat_q <= 1'b0;
      acc_q     <= '0;
      meas_q    <= '0;
      settle_q  <= '0;
      cap1_q    <= '0;
      cap2_q    <= '0;
    end else begin
      state_q   <= state_d;
      launch_q  <= launch_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      code_q    <= code_d;
      sat_q     <= sat_d;
      run_sat_q <= run_sat_d;
      acc_q     <= acc_d;
      meas_q    <= meas_d;
      settle_q  <= settle_d;
      cap1_q    <= cap1_d;
      cap2_q    <= cap2_d;
    end
  end

  assign LAUNCH = launch_q;
  assign BUSY   = busy_q;
  assign DONE   = done_q;
  assign CODE   = code_q;
  assign SAT    = sat_q;

endmodule

// File: doc/gf180mcu_dlyc_tap_calibrator.md
Name: gf180mcu_dlyc_tap_calibrator

Overview:
- Measurement controller placed directly downstream of a chain of dlyc delay cells.
- Drives the chain input with a launch edge, then captures all tap outputs one clock period later.
- Counts how many cells the edge crossed in one period and averages that count over 2^LOG_AVG measurements.
- The result feeds delay-trim and DLL-style code consumers.

Parameters:
N_TAPS, 32, number of delay-chain taps sampled (tap k = output of cell k, k=0 nearest the launch).
LOG_AVG, 2, log2 of measurements averaged per calibration (0..4).
SETTLE_CYC, 4, idle cycles after each capture so the whole chain settles before the next launch (>=1).
CW (local), clog2(N_TAPS+1), width of the result code.

Ports:
CLK  input  1  rising-edge clock; all state on this edge.
RN  input  1  asynchronous active-low reset.
START  input  1  single-cycle request; accepted only in IDLE, ignored otherwise.
LAUNCH  output  1  registered; drives the I pin of delay-chain cell 0.
TAP  input  N_TAPS  delay-chain tap outputs; asynchronous to CLK transitions.
BUSY  output  1  high from the cycle after START is accepted until DONE.
DONE  output  1  one-cycle pulse when CODE/SAT are updated.
CODE  output  CW  averaged count of taps crossed in one CLK period.
SAT  output  1  set if any measurement in the run crossed all N_TAPS taps (chain too short).

Behaviour:
- Reset (RN=0, asynchronous):
  - State = IDLE.
  - LAUNCH, BUSY, DONE, SAT = 0; CODE = 0.
  - Accumulator, measurement counter and capture registers = 0.
- Release of RN is synchronous to CLK; no action until START.
- States: IDLE, FIRE, CAP, SYNC, EVAL, SETTLE, DONE.
- IDLE + START=1 -> FIRE: clear accumulator, measurement counter and run-SAT; BUSY=1.
- FIRE (1 cycle): LAUNCH toggles at the exiting edge (edge E) -> CAP.
- CAP (1 cycle): at edge E+1, TAP is captured into cap1. This gives exactly one CLK period of propagation. -> SYNC.
- SYNC (1 cycle): cap1 -> cap2, as a second flop for metastability. -> EVAL.
- EVAL (1 cycle): compute count = number of leading taps (from tap 0 upward) with cap2[k] == LAUNCH.
  - Counting stops at the first mismatch, so bubbles beyond it are ignored.
  - count == N_TAPS sets run-SAT.
  - Accumulator += count; accumulator width is CW+LOG_AVG, so it never overflows.
  - Measurement counter increments.
  - Next state: SETTLE.
- SETTLE: stay SETTLE_CYC cycles.
  - Then -> FIRE if measurements < 2^LOG_AVG.
  - Otherwise -> DONE.
- DONE (1 cycle):
  - CODE <= accumulator >> LOG_AVG (truncation, no rounding).
  - SAT <= run-SAT.
  - DONE=1 and BUSY=0 in this cycle.
  - -> IDLE.
- CODE and SAT hold their values until the next DONE; they are not cleared by START.
- LAUNCH polarity alternates per measurement; rising and falling edges are both measured, so mixed-polarity averaging is intentional.
- START while BUSY: ignored, no queuing.
- START in the DONE cycle: ignored. START in the cycle after DONE (IDLE): accepted.
- Reset mid-run: everything returns to reset values immediately.
  - CODE returns to 0; no partial result is published.
  - LAUNCH=0 forces the chain back to 0.
- Latency from START to DONE: 2^LOG_AVG*(4+SETTLE_CYC)+1 cycles (the START-accept edge through the DONE cycle).
  - With defaults: 4*8+1 = 33.

Test Plan:
1. Bench chain model with 0.5 ns per cell, CLK period 10 ns, defaults. START -> each measurement count=20; DONE on cycle 33 with CODE=20, SAT=0; LAUNCH toggled 4 times, ending at 0.
2. Per-measurement counts 10, 11, 11, 12 (jittered cell delay), LOG_AVG=2 -> accumulator 44, CODE=11; counts 10, 10, 10, 11 -> CODE=10 (truncation).
3. Cell delay 0.2 ns (all 32 taps crossed) -> CODE=32, SAT=1; next run at 0.5 ns -> CODE=20, SAT=0.
4. Bubble: capture pattern taps 0..7 match, tap 8 mismatch, taps 9..12 match -> count=8, not 12.
5. START pulses at cycles 5 and 20 of a busy run, and in the DONE cycle -> exactly one DONE; a START one cycle after DONE starts a new run.
6. RN asserted during SETTLE of measurement 3, after a prior run gave CODE=20 -> LAUNCH, BUSY, DONE, SAT and CODE all 0 asynchronously; after release, START gives a fresh 33-cycle run.
